fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue.sv | 107 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: core control, memory request/response and instruction delivery.
// master = fetch_queue side, slave = core/memory environment side.
interface fetch_queue_if #(
    parameter int ADDR_W = 16,
    parameter int INS_W  = 16
);
    logic              core_en;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_val;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [INS_W-1:0]  mem_rdata;
    logic [INS_W-1:0]  ins;
    logic              ins_valid;
    logic [ADDR_W-1:0] ins_pc;

    modport master (
        input  core_en, branch_en, branch_val, stall, mem_ready, mem_rvalid, mem_rdata,
        output mem_req, mem_addr, ins, ins_valid, ins_pc
    );

    modport slave (
        output core_en, branch_en, branch_val, stall, mem_ready, mem_rvalid, mem_rdata,
        input  mem_req, mem_addr, ins, ins_valid, ins_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses
// with their addresses, and discards responses made stale by redirects or halts.
module fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INS_W    = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d, outs_q, outs_d, drop_q, drop_d;
    logic [INS_W-1:0]  ins_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q  [DEPTH];

    logic [CW:0] occ_sum;
    logic        flush, req, accept, beat, drop_beat, push, pop, valid;

    assign occ_sum   = {1'b0, cnt_q} + {1'b0, outs_q};
    assign flush     = bus.branch_en | ~bus.core_en;
    assign req       = ~rst & bus.core_en & ~bus.branch_en & (occ_sum < DEPTH_C);
    assign accept    = req & bus.mem_ready;
    assign beat      = bus.mem_rvalid & (outs_q != '0);
    assign drop_beat = beat & (drop_q != '0);
    assign push      = beat & (drop_q == '0) & ~flush;
    assign valid     = ~rst & bus.core_en & (cnt_q != '0);
    assign pop       = valid & ~bus.stall & ~bus.branch_en;

    assign bus.mem_req   = req;
    assign bus.mem_addr  = fpc_q;
    assign bus.ins_valid = valid;
    assign bus.ins       = valid ? ins_mem_q[rd_q] : '0;
    assign bus.ins_pc    = valid ? pc_mem_q[rd_q]  : '0;

    always_comb begin
        fpc_d  = fpc_q;
        rpc_d  = rpc_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        outs_d = outs_q + CW'(accept) - CW'(beat);
        drop_d = drop_q;

        if (accept)
            fpc_d = fpc_q + ADDR_W'(1);
        if (bus.branch_en)
            fpc_d = bus.branch_val;

        // rpc is the address of the next response that will be kept
        if (bus.branch_en)
            rpc_d = bus.branch_val;
        else if (!bus.core_en)
            rpc_d = fpc_q;
        else if (push)
            rpc_d = rpc_q + ADDR_W'(1);

        // After a redirect or halt every request still in flight is stale;
        // a beat landing this cycle is already discarded.
        if (flush) begin
            drop_d = outs_q - CW'(beat);
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
        end else begin
            if (drop_beat)
                drop_d = drop_q - CW'(1);
            wr_d  = wr_q + PW'(push);
            rd_d  = rd_q + PW'(pop);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q  <= RESET_PC;
            rpc_q  <= RESET_PC;
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            outs_q <= '0;
            drop_q <= '0;
        end else begin
            fpc_q  <= fpc_d;
            rpc_q  <= rpc_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            outs_q <= outs_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem_q[wr_q] <= bus.mem_rdata;
            pc_mem_q[wr_q]  <= rpc_q;
        end
    end
endmodule
